bcd_to_bin: RTL and testbench

- Converts a 4-digit packed BCD value (thousands, hundreds, tens, units) to an N-bit unsigned binary value. It is the inverse of the display-side binary-to-BCD path.
- Sits behind the digit-entry / switch-input logic and feeds binary operands to the datapath.
- Iterative multiply-by-10-and-add, one digit per clock, with valid/ready handshakes on input and output.

---
 rtl/bcd_pkg.sv | 18 +
 rtl/bcd_to_bin_if.sv | 30 +++
 rtl/bcd_mac10.sv | 26 ++
 rtl/bcd_to_bin.sv | 122 ++++++++++++
 tb/tb_bcd_to_bin.sv | 164 ++++++++++++++++
 5 files changed

// File: rtl/bcd_pkg.sv
// Shared types and constants for the BCD-to-binary converter.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int unsigned DIGIT_W    = 4;
  localparam int unsigned NUM_DIGITS = 4;
  localparam logic [DIGIT_W-1:0] MAX_DIGIT = 4'd9;

  function automatic logic digit_invalid(input logic [DIGIT_W-1:0] d);
    return d > MAX_DIGIT;
  endfunction

endpackage

// File: rtl/bcd_to_bin_if.sv
// Handshake bundle between digit-entry logic, the converter and the datapath.
interface bcd_to_bin_if
  import bcd_pkg::*;
#(
  parameter int N = 10
) ();

  logic               in_valid;
  logic               in_ready;
  logic [DIGIT_W-1:0] bcd_mil;
  logic [DIGIT_W-1:0] bcd_cen;
  logic [DIGIT_W-1:0] bcd_dec;
  logic [DIGIT_W-1:0] bcd_uni;
  logic               out_valid;
  logic               out_ready;
  logic [N-1:0]       bin_out;
  logic               ovf;
  logic               err;

  modport master (
    output in_valid, bcd_mil, bcd_cen, bcd_dec, bcd_uni, out_ready,
    input  in_ready, out_valid, bin_out, ovf, err
  );

  modport slave (
    input  in_valid, bcd_mil, bcd_cen, bcd_dec, bcd_uni, out_ready,
    output in_ready, out_valid, bin_out, ovf, err
  );

endinterface

// File: rtl/bcd_mac10.sv
// One conversion step: acc*10 + digit, wrapped to N bits, with carry-out detect.
module bcd_mac10
  import bcd_pkg::*;
#(
  parameter int N = 10
) (
  input  logic [N-1:0]       acc,
  input  logic [DIGIT_W-1:0] digit,
  output logic [N-1:0]       next,
  output logic               step_ovf
);

  localparam int W = N + 4;

  logic [W-1:0] ext;
  logic [W-1:0] wide;

  // Four spare bits hold 10*(2^N-1)+15 without loss.
  always_comb begin
    ext      = W'(acc);
    wide     = (ext << 3) + (ext << 1) + W'(digit);
    next     = wide[N-1:0];
    step_ovf = |wide[W-1:N];
  end

endmodule

// File: rtl/bcd_to_bin.sv
// 4-digit packed BCD to N-bit binary, one digit per clock, valid/ready on both sides.
// Define BCD_TO_BIN_SAT_EN to saturate bin_out to 2^N-1 on overflow.
module bcd_to_bin
  import bcd_pkg::*;
#(
  parameter int N      = 10,
  parameter int DIGITS = NUM_DIGITS
) (
  input logic         clk,
  input logic         rst,
  bcd_to_bin_if.slave bus
);

  state_t state;
  state_t state_nxt;

  logic [DIGITS-1:0][DIGIT_W-1:0] digit_q;
  logic [N-1:0] acc;
  logic [1:0]   idx;
  logic         ovf_acc;
  logic         err_acc;

  logic         out_valid_q;
  logic [N-1:0] bin_q;
  logic         ovf_q;
  logic         err_q;

  logic [N-1:0] mac_next;
  logic         mac_ovf;
  logic         ovf_final;
  logic [N-1:0] bin_final;
  logic         accept;
  logic         capture_err;

  bcd_mac10 #(.N(N)) u_mac (
    .acc      (acc),
    .digit    (digit_q[idx]),
    .next     (mac_next),
    .step_ovf (mac_ovf)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.in_valid) state_nxt = CONV;
      CONV:    if (idx == 2'd0)  state_nxt = DONE;
      DONE:    if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready = (state == IDLE);
  end

  always_comb begin
    accept      = (state == IDLE) && bus.in_valid;
    capture_err = digit_invalid(bus.bcd_mil) | digit_invalid(bus.bcd_cen) |
                  digit_invalid(bus.bcd_dec) | digit_invalid(bus.bcd_uni);
    ovf_final   = ovf_acc | mac_ovf;
`ifdef BCD_TO_BIN_SAT_EN
    bin_final   = ovf_final ? '1 : mac_next;
`else
    bin_final   = mac_next;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      digit_q     <= '0;
      acc         <= '0;
      idx         <= 2'(DIGITS - 1);
      ovf_acc     <= 1'b0;
      err_acc     <= 1'b0;
      out_valid_q <= 1'b0;
      bin_q       <= '0;
      ovf_q       <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            digit_q <= {bus.bcd_mil, bus.bcd_cen, bus.bcd_dec, bus.bcd_uni};
            acc     <= '0;
            idx     <= 2'(DIGITS - 1);
            ovf_acc <= 1'b0;
            err_acc <= capture_err;
          end
        end
        CONV: begin
          acc     <= mac_next;
          ovf_acc <= ovf_final;
          idx     <= idx - 2'd1;
          if (idx == 2'd0) begin
            out_valid_q <= 1'b1;
            err_q       <= err_acc;
            // An invalid digit masks both the value and the overflow flag.
            bin_q       <= err_acc ? '0 : bin_final;
            ovf_q       <= err_acc ? 1'b0 : ovf_final;
          end
        end
        DONE: begin
          if (bus.out_ready) out_valid_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.out_valid = out_valid_q;
    bus.bin_out   = bin_q;
    bus.ovf       = ovf_q;
    bus.err       = err_q;
  end

endmodule

// File: tb/tb_bcd_to_bin.sv
// Directed plus random checks of bcd_to_bin against a decimal arithmetic model.
module tb_bcd_to_bin;

  localparam int N = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_asrt = 0;
  int   n_fail = 0;

  bcd_to_bin_if #(.N(N)) bus ();

  bcd_to_bin #(.N(N), .DIGITS(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: value of the decimal number, reduced per the output rules.
  task automatic model(input int d3, input int d2, input int d1, input int d0,
                       output int unsigned bin, output int unsigned ov, output int unsigned er);
    int unsigned v;
    int unsigned lim;
    v   = d3 * 1000 + d2 * 100 + d1 * 10 + d0;
    lim = (1 << N) - 1;
    er  = (d3 > 9 || d2 > 9 || d1 > 9 || d0 > 9) ? 1 : 0;
    ov  = (er == 0 && v > lim) ? 1 : 0;
    if (er != 0) bin = 0;
`ifdef BCD_TO_BIN_SAT_EN
    else if (ov != 0) bin = lim;
`endif
    else bin = v % (1 << N);
  endtask

  task automatic scramble();
    bus.bcd_mil = 4'($urandom);
    bus.bcd_cen = 4'($urandom);
    bus.bcd_dec = 4'($urandom);
    bus.bcd_uni = 4'($urandom);
  endtask

  task automatic convert(input int d3, input int d2, input int d1, input int d0,
                         input int hold, input bit wiggle);
    int unsigned eb, eo, ee;
    int lat;
    int k;
    k = 0;
    while (!bus.in_ready && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    check("in_ready_idle", bus.in_ready, 1);
    bus.in_valid  = 1'b1;
    bus.bcd_mil   = 4'(d3);
    bus.bcd_cen   = 4'(d2);
    bus.bcd_dec   = 4'(d1);
    bus.bcd_uni   = 4'(d0);
    bus.out_ready = (hold == 0);
    @(posedge clk); #1;
    check("in_ready_busy", bus.in_ready, 0);
    if (wiggle) scramble();
    else bus.in_valid = 1'b0;
    lat = 0;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid) begin
        lat = i;
        break;
      end
      if (wiggle) scramble();
    end
    bus.in_valid = 1'b0;
    check("latency", lat, 4);
    model(d3, d2, d1, d0, eb, eo, ee);
    check("bin_out", bus.bin_out, eb);
    check("ovf", bus.ovf, eo);
    check("err", bus.err, ee);
    for (int h = 0; h < hold; h++) begin
      bus.in_valid = 1'b1;
      scramble();
      @(posedge clk); #1;
      check("hold_valid", bus.out_valid, 1);
      check("hold_bin", bus.bin_out, eb);
      check("hold_in_ready", bus.in_ready, 0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    check("drain_valid", bus.out_valid, 0);
    check("drain_in_ready", bus.in_ready, 1);
    if (hold > 0) begin
      @(posedge clk); #1;
      check("no_spurious_accept", bus.in_ready, 1);
    end
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.bcd_mil   = '0;
    bus.bcd_cen   = '0;
    bus.bcd_dec   = '0;
    bus.bcd_uni   = '0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_bin", bus.bin_out, 0);
    check("rst_ovf", bus.ovf, 0);
    check("rst_err", bus.err, 0);

    convert(0, 9, 9, 9, 0, 1'b0);
    convert(1, 2, 3, 4, 0, 1'b0);
    convert(0, 0, 0, 0, 0, 1'b0);
    convert(0, 10, 1, 2, 0, 1'b0);
    convert(0, 0, 4, 2, 3, 1'b0);
    convert(1, 0, 2, 3, 0, 1'b1);
    convert(1, 0, 2, 4, 0, 1'b0);
    convert(9, 9, 9, 9, 1, 1'b1);
    convert(15, 15, 15, 15, 0, 1'b0);

    // Abort a conversion with reset on its second CONV edge.
    bus.in_valid  = 1'b1;
    bus.bcd_mil   = 4'd9;
    bus.bcd_cen   = 4'd9;
    bus.bcd_dec   = 4'd9;
    bus.bcd_uni   = 4'd9;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_in_ready", bus.in_ready, 1);
    check("abort_out_valid", bus.out_valid, 0);
    check("abort_bin", bus.bin_out, 0);
    check("abort_ovf", bus.ovf, 0);
    check("abort_err", bus.err, 0);
    convert(0, 0, 0, 7, 0, 1'b0);

    for (int t = 0; t < 40; t++) begin
      int d[4];
      for (int j = 0; j < 4; j++)
        d[j] = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 9));
      convert(d[3], d[2], d[1], d[0], int'($urandom_range(0, 2)), 1'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
